// File: rtl/ssd_display_driver.sv
// Converts a binary value to BCD with a sequential double-dabble engine and
// time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
module ssd_display_driver #(
  parameter int IN_W        = 13,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   value_in,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + IN_W;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BIT_W = $clog2(IN_W + 1);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] DIGIT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IN_W-1:0]   last_val_q, last_val_d;
  logic              pending_q, pending_d;
  logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [SH_W-1:0]   adj;
  logic [3:0]        nibble;
  logic              blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      last_val_q <= '0;
      pending_q  <= 1'b1;
      disp_bcd_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= ~DIGIT0;
      seg_q      <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      last_val_q <= last_val_d;
      pending_q  <= pending_d;
      disp_bcd_q <= disp_bcd_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  // Conversion engine: the display register is only written once a full
  // conversion finishes, so a digit never shows a partial result.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_val_d = last_val_q;
    pending_d  = pending_q;
    disp_bcd_d = disp_bcd_q;
    adj        = shreg_q;
    case (state_q)
      IDLE: begin
        if (pending_q || (value_in != last_val_q)) begin
          shreg_d    = {{BCD_W{1'b0}}, value_in};
          last_val_d = value_in;
          bit_cnt_d  = BIT_W'(IN_W);
          pending_d  = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (adj[IN_W + 4*k +: 4] >= 4'd5) begin
            adj[IN_W + 4*k +: 4] = adj[IN_W + 4*k +: 4] + 4'd3;
          end
        end
        shreg_d   = adj << 1;
        bit_cnt_d = bit_cnt_q - BIT_W'(1);
        if (bit_cnt_q == BIT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_bcd_d = shreg_q[SH_W-1 -: BCD_W];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh: segments are computed from next-state values so an/seg always
  // track digit_idx and disp_bcd on the same edge.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
    an_d   = ~(DIGIT0 << idx_d);
    nibble = disp_bcd_d[{idx_d, 2'b00} +: 4];
    blank  = (idx_d != '0) && ((disp_bcd_d >> {idx_d, 2'b00}) == '0);
    seg_d  = blank ? 7'b1111111 : decode(nibble);
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = (state_q != IDLE);

endmodule
